// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage store buffer.
package dmem_pkg;
  localparam int SB_AW     = 32;
  localparam int SB_DW     = 32;
  localparam int WORD_LSB  = 2;
  localparam int RAM_WORDS = 32;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding lookup: compares every buffer entry against the load
// word address and returns the youngest matching entry's data.
module sb_fwd_match
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                       ent_valid [DEPTH],
  input  logic [AW-1:WORD_LSB]       ent_word  [DEPTH],
  input  logic [DW-1:0]              ent_data  [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic [AW-1:WORD_LSB]       ld_word,
  output logic                       hit,
  output logic [DW-1:0]              data
);
  localparam int PW = $clog2(DEPTH);

  // Walk oldest to youngest so the last match seen (the youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx  = '0;
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ent_valid[idx] && (ent_word[idx] == ld_word)) begin
        hit  = 1'b1;
        data = ent_data[idx];
      end
    end
  end
endmodule

// File: rtl/dmem_store_buffer.sv
// MEM-stage store buffer: queues stores, drains them into the data RAM when no load
// misses need the port, and forwards buffered data to loads.
// Optional build macro STBUF_COALESCE_EN merges a store into a matching youngest entry.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [DW-1:0]              st_data,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  output logic                       ld_ready,
  output logic [DW-1:0]              ld_data,
  output logic                       ld_hit,
  output logic                       ram_we,
  output logic [AW-1:0]              ram_addr,
  output logic [DW-1:0]              ram_datain,
  input  logic [DW-1:0]              ram_dataout,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a store is taken on any cycle with st_valid & st_ready; a load
  // completes on any cycle with ld_valid & ld_ready, otherwise MEM must hold it.
  sb_entry_t           entries [DEPTH];
  logic [PW-1:0]       head, tail, youngest;
  logic [CW-1:0]       count;
  logic                full, hit, load_miss, drain, coal, push;
  logic [DW-1:0]       fwd_data;
  logic                ent_valid [DEPTH];
  logic [AW-1:WORD_LSB] ent_word [DEPTH];
  logic [DW-1:0]       ent_data  [DEPTH];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      ent_valid[k] = entries[k].valid;
      ent_word[k]  = entries[k].addr[AW-1:WORD_LSB];
      ent_data[k]  = entries[k].data;
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match (
    .ent_valid (ent_valid),
    .ent_word  (ent_word),
    .ent_data  (ent_data),
    .head      (head),
    .ld_word   (ld_addr[AW-1:WORD_LSB]),
    .hit       (hit),
    .data      (fwd_data)
  );

  assign full      = (count == CW'(DEPTH));
  assign youngest  = tail - PW'(1);
  assign load_miss = ld_valid & ~hit;
  // A full buffer always drains, even over a missing load, so stores can't starve.
  assign drain     = (count != '0) & (full | ~load_miss);

`ifdef STBUF_COALESCE_EN
  assign coal = st_valid && (count != '0) &&
                (entries[youngest].addr[AW-1:WORD_LSB] == st_addr[AW-1:WORD_LSB]) &&
                !(drain && (youngest == head));
`else
  assign coal = 1'b0;
`endif

  assign st_ready   = ~full | drain | coal;
  assign push       = st_valid & st_ready & ~coal;
  assign ld_hit     = ld_valid & hit;
  assign ld_ready   = ld_valid & ~(full & load_miss);
  assign ld_data    = hit ? fwd_data : ram_dataout;
  assign ram_we     = drain;
  assign ram_addr   = drain ? entries[head].addr : ld_addr;
  assign ram_datain = entries[head].data;
  assign sb_empty   = (count == '0);
  assign sb_count   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int k = 0; k < DEPTH; k++) entries[k] <= '0;
    end else begin
      // Pop before push: when full, head==tail and the new entry must win.
      if (drain) begin
        entries[head].valid <= 1'b0;
        head <= head + PW'(1);
      end
      if (coal) entries[youngest].data <= st_data;
      if (push) begin
        entries[tail] <= '{valid: 1'b1, addr: st_addr, data: st_data};
        tail <= tail + PW'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: queue-based buffer model plus an
// architectural memory image that every completed load must agree with.
module tb_dmem_store_buffer;
  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        st_valid, st_ready, ld_valid, ld_ready, ld_hit, ram_we, sb_empty;
  logic [31:0] st_addr, st_data, ld_addr, ld_data, ram_addr, ram_datain, ram_dataout;
  logic [2:0]  sb_count;

  logic [31:0] ram_mem [32];
  logic [31:0] gold    [32];
  logic [63:0] exp_q [$];
  int          checks, failures;
  logic [31:0] o_ld_data, o_ram_addr, o_ram_datain;
  logic        o_ld_hit, o_ld_ready, o_ram_we, o_sb_empty, o_st_ready;
  logic [2:0]  o_sb_count;

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_data(ld_data),
    .ld_hit(ld_hit), .ram_we(ram_we), .ram_addr(ram_addr), .ram_datain(ram_datain),
    .ram_dataout(ram_dataout), .sb_empty(sb_empty), .sb_count(sb_count)
  );

  // Clock / reset and the 32x32 RAM (sync write, async read).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign ram_dataout = ram_mem[ram_addr[6:2]];
  always @(posedge clk) if (ram_we) ram_mem[ram_addr[6:2]] <= ram_datain;

  function automatic logic [31:0] mk(input logic [4:0] w);
    return {25'b0, w, 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check at negedge against the model, advance model at posedge.
  task automatic step(input logic sv, input logic [4:0] sw, input logic [31:0] sd,
                      input logic lv, input logic [4:0] lw);
    int n;
    logic hit, full, miss, drn, coal, srdy, lrdy;
    st_valid = sv; st_addr = mk(sw); st_data = sd;
    ld_valid = lv; ld_addr = mk(lw);
    @(negedge clk);
    n = exp_q.size();
    hit = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][63:32] == mk(lw)) hit = 1'b1;
    full = (n == DEPTH);
    miss = lv && !hit;
    drn  = (n > 0) && (full || !miss);
`ifdef STBUF_COALESCE_EN
    coal = sv && (n > 0) && (exp_q[n-1][63:32] == mk(sw)) && !(drn && n == 1);
`else
    coal = 1'b0;
`endif
    srdy = coal || !full || drn;
    lrdy = lv && !(full && miss);
    chk("sb_count", 32'(sb_count), 32'(n));
    chk("sb_empty", 32'(sb_empty), 32'(n == 0));
    chk("st_ready", 32'(st_ready), 32'(srdy));
    chk("ld_ready", 32'(ld_ready), 32'(lrdy));
    chk("ld_hit",   32'(ld_hit),   32'(lv && hit));
    chk("ram_we",   32'(ram_we),   32'(drn));
    if (drn) begin
      chk("ram_addr_drain", ram_addr, exp_q[0][63:32]);
      chk("ram_datain", ram_datain, exp_q[0][31:0]);
    end else begin
      chk("ram_addr_idle", ram_addr, mk(lw));
    end
    if (lrdy) chk("ld_data", ld_data, gold[lw]);
    o_ld_data = ld_data; o_ld_hit = ld_hit; o_ld_ready = ld_ready; o_ram_we = ram_we;
    o_ram_addr = ram_addr; o_ram_datain = ram_datain; o_sb_empty = sb_empty;
    o_sb_count = sb_count; o_st_ready = st_ready;
    @(posedge clk);
    if (coal) exp_q[n-1][31:0] = sd;
    if (drn) void'(exp_q.pop_front());
    if (sv && srdy) begin
      if (!coal) exp_q.push_back({mk(sw), sd});
      gold[sw] = sd;
    end
    #1;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < 32; i++) begin
      ram_mem[i] = $urandom;
      gold[i] = ram_mem[i];
    end
    rst_n = 1'b0; st_valid = 1'b0; ld_valid = 1'b0;
    st_addr = '0; st_data = '0; ld_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk("rst_sb_count", 32'(sb_count), 32'd0);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_ram_we",   32'(ram_we),   32'd0);
    chk("rst_ld_hit",   32'(ld_hit),   32'd0);
    chk("rst_ld_data",  ld_data, gold[0]);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single store drains on the next idle cycle.
    step(1'b1, 5'd5, 32'h0000_00A3, 1'b0, 5'd0);
    idle(1);
    chk("lit_drain_we",   32'(o_ram_we), 32'd1);
    chk("lit_drain_addr", o_ram_addr, 32'h14);
    chk("lit_drain_data", o_ram_datain, 32'hA3);
    idle(1);
    chk("lit_empty_again", 32'(o_sb_empty), 32'd1);

    // Forwarding one cycle after acceptance.
    step(1'b1, 5'd21, 32'h11, 1'b1, 5'd31);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd21);
    chk("lit_fwd_hit",  32'(o_ld_hit), 32'd1);
    chk("lit_fwd_data", o_ld_data, 32'h11);
    idle(2);

    // Two stores to the same word: youngest forwarded.
    step(1'b1, 5'd0, 32'd1, 1'b1, 5'd31);
    step(1'b1, 5'd0, 32'd2, 1'b1, 5'd31);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    chk("lit_youngest", o_ld_data, 32'd2);
`ifdef STBUF_COALESCE_EN
    chk("lit_dup_count", 32'(o_sb_count), 32'd1);
`else
    chk("lit_dup_count", 32'(o_sb_count), 32'd2);
`endif
    idle(3);

    // Fill under missing loads, then full-miss forces a drain and stalls the load.
    for (int i = 0; i < 4; i++) step(1'b1, 5'(8 + i), 32'(100 + i), 1'b1, 5'd30);
    step(1'b1, 5'd12, 32'd104, 1'b1, 5'd30);
    chk("lit_full_count",  32'(o_sb_count), 32'd4);
    chk("lit_full_ldrdy",  32'(o_ld_ready), 32'd0);
    chk("lit_full_we",     32'(o_ram_we), 32'd1);
    chk("lit_full_addr",   o_ram_addr, 32'h20);
    chk("lit_full_strdy",  32'(o_st_ready), 32'd1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd30);
    chk("lit_full_stays4", 32'(o_sb_count), 32'd4);
    for (int i = 0; i < 8; i++) step(1'b1, 5'(16 + i), 32'(200 + i), 1'b1, 5'd29);
    idle(6);

    // Asynchronous reset while entries are waiting to drain.
    for (int i = 0; i < 3; i++) step(1'b1, 5'(1 + i), 32'(300 + i), 1'b1, 5'd31);
    st_valid = 1'b0; ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_empty", 32'(sb_empty), 32'd1);
    chk("lit_rst_we",    32'(ram_we), 32'd0);
    chk("lit_rst_count", 32'(sb_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 32; i++) gold[i] = ram_mem[i];
    @(posedge clk); #1;
    idle(2);

    // Randomised traffic on a small address set to force matches and fullness.
    for (int c = 0; c < 3000; c++)
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)));
    idle(8);
    for (int i = 0; i < 32; i++) chk("final_mem", ram_mem[i], gold[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
